// File: rtl/rtc_multi_alarm_if.sv
// Configuration bus of the multi-alarm RTC: validated time-set port and
// alarm-channel write port, with the shared reject pulse.
interface rtc_multi_alarm_if #(
    parameter int IW = 2
);
    logic          set_valid;
    logic [4:0]    set_hour;
    logic [5:0]    set_min;
    logic [5:0]    set_sec;
    logic          set_err;
    logic          alm_wr;
    logic [IW-1:0] alm_idx;
    logic [4:0]    alm_hour;
    logic [5:0]    alm_min;
    logic          alm_en;

    modport master (
        output set_valid, set_hour, set_min, set_sec,
        output alm_wr, alm_idx, alm_hour, alm_min, alm_en,
        input  set_err
    );

    modport slave (
        input  set_valid, set_hour, set_min, set_sec,
        input  alm_wr, alm_idx, alm_hour, alm_min, alm_en,
        output set_err
    );
endinterface

// File: rtl/rtc_multi_alarm.sv
// 24-hour real-time clock with NUM_ALARMS independent alarm channels, each
// with ring timeout, snooze and dismiss, plus a 12/24-hour display output.
module rtc_multi_alarm #(
    parameter int CLK_HZ     = 10,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic                  clk,
    input  logic                  rst,
    rtc_multi_alarm_if.slave      bus,
    input  logic                  snooze,
    input  logic                  dismiss,
    input  logic                  mode_12h,
    output logic [5:0]            sec,
    output logic [5:0]            min,
    output logic [4:0]            hour,
    output logic [4:0]            disp_hour,
    output logic                  pm,
    output logic                  tick_1hz,
    output logic [NUM_ALARMS-1:0] alarm_active,
    output logic                  alarm_out
);
    localparam int              IW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [31:0]     NA_U     = 32'(NUM_ALARMS);
    localparam logic [16:0]     RING_T   = 17'(RING_SEC);
    localparam logic [16:0]     SNOOZE_T = 17'(SNOOZE_SEC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } ch_state_e;

    logic [PW-1:0]                presc_q, presc_d;
    logic [5:0]                   sec_q, sec_d;
    logic [5:0]                   min_q, min_d;
    logic [4:0]                   hour_q, hour_d;
    logic                         tick_q, tick_s;
    logic                         set_err_q, set_err_d;
    logic [NUM_ALARMS-1:0][4:0]   alm_hour_q, alm_hour_d;
    logic [NUM_ALARMS-1:0][5:0]   alm_min_q, alm_min_d;
    logic [NUM_ALARMS-1:0]        alm_en_q, alm_en_d;
    ch_state_e                    state_q [NUM_ALARMS];
    ch_state_e                    state_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0][16:0]  timer_q, timer_d;
    logic [NUM_ALARMS-1:0]        active_q, active_d;
    logic                         alarm_out_q, alarm_out_d;
    logic                         set_ok_s, wr_ok_s;
    logic [NUM_ALARMS-1:0]        wr_hit_s, match_s;

    // State register for timekeeping, alarm configuration and channel FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            tick_q      <= 1'b0;
            set_err_q   <= 1'b0;
            alm_hour_q  <= '0;
            alm_min_q   <= '0;
            alm_en_q    <= '0;
            timer_q     <= '0;
            active_q    <= '0;
            alarm_out_q <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            tick_q      <= tick_s;
            set_err_q   <= set_err_d;
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            alm_en_q    <= alm_en_d;
            timer_q     <= timer_d;
            active_q    <= active_d;
            alarm_out_q <= alarm_out_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Prescaler, time-of-day advance and validated time set (set beats tick)
    always_comb begin
        set_ok_s  = bus.set_valid && (bus.set_hour <= 5'd23) &&
                    (bus.set_min <= 6'd59) && (bus.set_sec <= 6'd59);
        wr_ok_s   = bus.alm_wr && (bus.alm_hour <= 5'd23) &&
                    (bus.alm_min <= 6'd59) && (32'(bus.alm_idx) < NA_U);
        set_err_d = (bus.set_valid && !set_ok_s) || (bus.alm_wr && !wr_ok_s);
        tick_s    = (presc_q == PRESC_TC) && !set_ok_s;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        if (set_ok_s) begin
            presc_d = '0;
            sec_d   = bus.set_sec;
            min_d   = bus.set_min;
            hour_d  = bus.set_hour;
        end else if (tick_s) begin
            presc_d = '0;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Alarm register writes and per-channel IDLE/RINGING/SNOOZED next state.
    // Matches compare against the pre-write alarm registers.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wr_hit_s[i]   = wr_ok_s && (bus.alm_idx == IW'(i));
            alm_hour_d[i] = wr_hit_s[i] ? bus.alm_hour : alm_hour_q[i];
            alm_min_d[i]  = wr_hit_s[i] ? bus.alm_min  : alm_min_q[i];
            alm_en_d[i]   = wr_hit_s[i] ? bus.alm_en   : alm_en_q[i];
            match_s[i]    = tick_s && (sec_d == 6'd0) && alm_en_q[i] &&
                            (hour_d == alm_hour_q[i]) && (min_d == alm_min_q[i]);
            state_d[i]    = state_q[i];
            timer_d[i]    = timer_q[i];
            if (wr_hit_s[i] && !bus.alm_en) begin
                state_d[i] = ST_IDLE;
                timer_d[i] = 17'd0;
            end else if (dismiss && (state_q[i] != ST_IDLE)) begin
                state_d[i] = ST_IDLE;
                timer_d[i] = 17'd0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (match_s[i]) begin
                            state_d[i] = ST_RINGING;
                            timer_d[i] = RING_T;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_RINGING: begin
                        if (snooze) begin
                            state_d[i] = ST_SNOOZED;
                            timer_d[i] = SNOOZE_T;
                        end else if (tick_s) begin
                            if (timer_q[i] <= 17'd1) begin
                                state_d[i] = ST_IDLE;
                                timer_d[i] = 17'd0;
                            end else begin
                                timer_d[i] = timer_q[i] - 17'd1;
                            end
                        end else begin
                            timer_d[i] = timer_q[i];
                        end
                    end
                    ST_SNOOZED: begin
                        if (tick_s) begin
                            if (timer_q[i] <= 17'd1) begin
                                state_d[i] = ST_RINGING;
                                timer_d[i] = RING_T;
                            end else begin
                                timer_d[i] = timer_q[i] - 17'd1;
                            end
                        end else begin
                            timer_d[i] = timer_q[i];
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = 17'd0;
                    end
                endcase
            end
            active_d[i] = (state_d[i] == ST_RINGING);
        end
        alarm_out_d = |active_d;
    end

    // 12/24-hour display mapping from the registered hour
    always_comb begin
        if (mode_12h) begin
            pm = (hour_q >= 5'd12);
            if (hour_q == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_q <= 5'd12) begin
                disp_hour = hour_q;
            end else begin
                disp_hour = hour_q - 5'd12;
            end
        end else begin
            pm        = 1'b0;
            disp_hour = hour_q;
        end
    end

    assign sec          = sec_q;
    assign min          = min_q;
    assign hour         = hour_q;
    assign tick_1hz     = tick_q;
    assign bus.set_err  = set_err_q;
    assign alarm_active = active_q;
    assign alarm_out    = alarm_out_q;
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed-vector bench for rtc_multi_alarm with CLK_HZ=10, four channels,
// RING_SEC=3 and SNOOZE_SEC=2; inputs driven and outputs sampled on negedge.
module tb_rtc_multi_alarm;
    logic       clk = 1'b0;
    logic       rst;
    logic       snooze, dismiss, mode_12h;
    logic [5:0] sec, min;
    logic [4:0] hour, disp_hour;
    logic       pm, tick_1hz, alarm_out;
    logic [3:0] alarm_active;
    int         n_vec = 0;
    int         n_bad = 0;

    rtc_multi_alarm_if #(.IW(2)) bus ();

    rtc_multi_alarm #(
        .CLK_HZ(10), .NUM_ALARMS(4), .RING_SEC(3), .SNOOZE_SEC(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .snooze(snooze), .dismiss(dismiss), .mode_12h(mode_12h),
        .sec(sec), .min(min), .hour(hour), .disp_hour(disp_hour), .pm(pm),
        .tick_1hz(tick_1hz), .alarm_active(alarm_active), .alarm_out(alarm_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_val({tag, "_hour"}, 32'(hour), 32'(h));
        check_val({tag, "_min"},  32'(min),  32'(m));
        check_val({tag, "_sec"},  32'(sec),  32'(s));
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.set_valid = 1'b1;
        bus.set_hour  = 5'(h);
        bus.set_min   = 6'(m);
        bus.set_sec   = 6'(s);
        cyc(1);
        bus.set_valid = 1'b0;
    endtask

    task automatic alm_write(input int idx, input int h, input int m, input logic en);
        bus.alm_wr   = 1'b1;
        bus.alm_idx  = 2'(idx);
        bus.alm_hour = 5'(h);
        bus.alm_min  = 6'(m);
        bus.alm_en   = en;
        cyc(1);
        bus.alm_wr   = 1'b0;
    endtask

    task automatic check_disp(input int h, input logic m12, input int exp_disp, input logic exp_pm);
        set_time(h, 0, 0);
        mode_12h = m12;
        #1;
        check_val("disp_hour", 32'(disp_hour), 32'(exp_disp));
        check_val("pm",        32'(pm),        32'(exp_pm));
    endtask

    initial begin
        rst = 1'b1; snooze = 1'b0; dismiss = 1'b0; mode_12h = 1'b0;
        bus.set_valid = 1'b0; bus.set_hour = 5'd0; bus.set_min = 6'd0; bus.set_sec = 6'd0;
        bus.alm_wr = 1'b0; bus.alm_idx = 2'd0; bus.alm_hour = 5'd0; bus.alm_min = 6'd0;
        bus.alm_en = 1'b0;
        cyc(2);
        rst = 1'b0;
        check_time("reset", 0, 0, 0);
        check_val("reset_tick",  32'(tick_1hz),  32'd0);
        check_val("reset_out",   32'(alarm_out), 32'd0);
        check_val("reset_err",   32'(bus.set_err), 32'd0);

        // First second after reset
        cyc(9);
        check_val("pre_tick_sec", 32'(sec), 32'd0);
        check_val("pre_tick",     32'(tick_1hz), 32'd0);
        cyc(1);
        check_val("tick_sec", 32'(sec), 32'd1);
        check_val("tick_hi",  32'(tick_1hz), 32'd1);
        cyc(1);
        check_val("tick_lo",  32'(tick_1hz), 32'd0);

        // Midnight rollover
        set_time(23, 59, 59);
        check_time("set", 23, 59, 59);
        cyc(10);
        check_time("rollover", 0, 0, 0);

        // Out-of-range set rejected; prescaler now at 0
        set_time(0, 60, 0);
        check_val("bad_set_err", 32'(bus.set_err), 32'd1);
        check_time("bad_set", 0, 0, 0);
        cyc(1);
        check_val("err_pulse", 32'(bus.set_err), 32'd0);

        // Set on the prescaler terminal cycle: prescaler is 2, reach 9
        cyc(7);
        set_time(7, 30, 0);
        check_val("set_tc_tick", 32'(tick_1hz), 32'd0);
        check_time("set_tc", 7, 30, 0);
        cyc(9);
        check_val("presc_clr_sec", 32'(sec), 32'd0);
        cyc(1);
        check_val("presc_clr_tick", 32'(sec), 32'd1);

        // Channel 2 rings at 07:31 for three ticks
        alm_write(2, 7, 31, 1'b1);
        check_val("alm_wr_err", 32'(bus.set_err), 32'd0);
        set_time(7, 30, 59);
        cyc(9);
        check_val("pre_match", 32'(alarm_out), 32'd0);
        cyc(1);
        check_time("match", 7, 31, 0);
        check_val("match_act", 32'(alarm_active), 32'd4);
        check_val("match_out", 32'(alarm_out), 32'd1);
        cyc(20);
        check_val("ring_2tick", 32'(alarm_active), 32'd4);
        cyc(10);
        check_val("ring_timeout", 32'(alarm_active), 32'd0);

        // Snooze for two ticks, then re-ring
        set_time(7, 30, 59);
        cyc(10);
        check_val("ring_again", 32'(alarm_active), 32'd4);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        check_val("snoozed", 32'(alarm_out), 32'd0);
        cyc(9);
        check_val("snz_tick1", 32'(alarm_out), 32'd0);
        cyc(9);
        check_val("snz_pre2", 32'(alarm_out), 32'd0);
        cyc(1);
        check_val("rering", 32'(alarm_active), 32'd4);

        // Dismiss beats snooze
        snooze = 1'b1; dismiss = 1'b1;
        cyc(1);
        snooze = 1'b0; dismiss = 1'b0;
        check_val("dismiss", 32'(alarm_out), 32'd0);
        cyc(30);
        check_val("no_rering", 32'(alarm_out), 32'd0);

        // Two channels match together, then one is disabled
        alm_write(0, 8, 0, 1'b1);
        alm_write(3, 8, 0, 1'b1);
        set_time(7, 59, 59);
        cyc(10);
        check_val("dual_act", 32'(alarm_active), 32'd9);
        alm_write(0, 8, 0, 1'b0);
        check_val("disable_act", 32'(alarm_active), 32'd8);
        check_val("disable_out", 32'(alarm_out), 32'd1);
        alm_write(1, 24, 0, 1'b1);
        check_val("bad_alm_err", 32'(bus.set_err), 32'd1);

        // Reset while ringing
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_val("rst_act", 32'(alarm_active), 32'd0);
        check_val("rst_out", 32'(alarm_out), 32'd0);
        check_val("rst_err", 32'(bus.set_err), 32'd0);
        check_time("rst_time", 0, 0, 0);

        // Alarm registers were cleared by reset
        set_time(7, 59, 59);
        cyc(10);
        check_val("post_rst_hour", 32'(hour), 32'd8);
        check_val("post_rst_out",  32'(alarm_out), 32'd0);

        // Display mapping
        check_disp(0,  1'b1, 12, 1'b0);
        check_disp(12, 1'b1, 12, 1'b1);
        check_disp(13, 1'b1, 1,  1'b1);
        check_disp(23, 1'b1, 11, 1'b1);
        check_disp(13, 1'b0, 13, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rtc_multi_alarm.md
Name: rtc_multi_alarm

Overview:
Parametrised 24-hour real-time clock with N independently programmable alarm channels. Each channel supports snooze, dismiss and auto-timeout. Adds a validated time-set port and a 12/24-hour display output. Sits between the board clock domain and the display/buzzer logic, and replaces the single-alarm RTC in new designs.

Parameters:
CLK_HZ, 10, clk cycles per second; prescaler terminal count is CLK_HZ-1 (100000000 on Basys 3)
NUM_ALARMS, 4, number of alarm channels (>=1); IW = max(1, clog2(NUM_ALARMS))
RING_SEC, 60, seconds a channel rings before auto-timeout
SNOOZE_SEC, 300, seconds a channel stays snoozed before re-ringing

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
set_valid  in  1  load time on this cycle
set_hour  in  5  0..23
set_min  in  6  0..59
set_sec  in  6  0..59
set_err  out  1  one-cycle pulse: set or alarm write rejected
alm_wr  in  1  write alarm channel alm_idx
alm_idx  in  IW  channel index
alm_hour  in  5  0..23
alm_min  in  6  0..59
alm_en  in  1  enable bit written with alm_wr
snooze  in  1  pulse: snooze all ringing channels
dismiss  in  1  pulse: stop all ringing/snoozed channels
mode_12h  in  1  1 = 12-hour display format
sec  out  6  seconds, 24h
min  out  6  minutes
hour  out  5  hours 0..23
disp_hour  out  5  display hour
pm  out  1  PM flag (12h mode only)
tick_1hz  out  1  one-cycle pulse when time advances
alarm_active  out  NUM_ALARMS  per-channel ringing (RINGING state)
alarm_out  out  1  OR of alarm_active

Behaviour:
- Reset: sec/min/hour=0, prescaler=0, all alarm regs hour=0/min=0/en=0, all channels IDLE, timers=0, set_err=0, tick_1hz=0, alarm_active=0, alarm_out=0.
- Prescaler: counts 0..CLK_HZ-1. At terminal count it wraps to 0 and asserts tick_1hz (registered) in the same cycle time advances. Wrap order: sec 59->0 carries min; min 59->0 carries hour; 23:59:59 -> 00:00:00.
- Time set: set_valid with all fields in range loads sec/min/hour next cycle, clears the prescaler and suppresses any tick that cycle (set wins). If any field is out of range: no change, set_err=1 for one cycle.
- Alarm write: alm_wr loads hour/min/en into channel alm_idx. Out of range (hour>23, min>59, or alm_idx>=NUM_ALARMS): no write, set_err=1. Writing en=0 forces that channel to IDLE next cycle.
- Match: evaluated only on a tick whose new time is hh:mm:00 and equals an enabled channel's hour/min. Fires once per day. Setting time into an alarm minute does not fire. A match on the same cycle as alm_wr uses the pre-write register values.
- Per-channel FSM (IDLE, RINGING, SNOOZED), 17-bit seconds timer:
  IDLE -> RINGING on match; timer=RING_SEC.
  RINGING: timer decrements on each tick; at 0 -> IDLE. snooze -> SNOOZED, timer=SNOOZE_SEC.
  SNOOZED: timer decrements on each tick; at 0 -> RINGING, timer=RING_SEC.
  dismiss: RINGING or SNOOZED -> IDLE.
  Simultaneous dismiss+snooze: dismiss wins. Match while RINGING/SNOOZED: ignored.
- alarm_active[i] = (state==RINGING), registered; alarm_out = OR of alarm_active.
- Display (combinational from registered hour): mode_12h=0 gives disp_hour=hour, pm=0. mode_12h=1 gives hour 0 -> 12, 1..12 -> hour, 13..23 -> hour-12; pm = (hour>=12).
- rst mid-operation: all state returns to reset values on the next edge, including ringing/snoozed channels.

Test Plan:
- CLK_HZ=10: from reset run 10 cycles -> sec=1, tick_1hz high exactly 1 cycle; set 23:59:59, wait 10 cycles -> 00:00:00.
- set_valid with set_min=60 -> set_err pulse, time unchanged. Set 07:30:00 on the prescaler terminal cycle -> time=07:30:00, prescaler=0, no tick.
- Ch2 alarm 07:31 en=1, set 07:30:59 -> after 1 tick alarm_active=4'b0100, alarm_out=1. RING_SEC=3 -> IDLE after 3 ticks.
- Ringing, snooze (SNOOZE_SEC=2) -> alarm_out=0 for 2 ticks, then re-rings. dismiss+snooze same cycle -> IDLE, no re-ring.
- Ch0 and ch3 both 08:00, reach 08:00:00 -> alarm_active=4'b1001. alm_wr ch0 en=0 -> alarm_active=4'b1000 next cycle.
- mode_12h=1: hour 0 -> disp 12/pm 0; 12 -> 12/pm 1; 13 -> 1/pm 1. Reset while ringing -> all outputs 0 next cycle.
